// File: rtl/fixed_point_pkg.sv
// -----------------------------------------------------------------------------
// fixed_point_pkg
// Shared definitions for the sequential fixed-point arithmetic blocks.
//   state_e        : multiplier control states (IDLE, MUL, FINISH)
//   ROUND_TRUNC    : round_mode value selecting floor (arithmetic shift)
//   ROUND_HALF_UP  : round_mode value selecting round-half-up
// -----------------------------------------------------------------------------
package fixed_point_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    localparam logic ROUND_TRUNC   = 1'b0;
    localparam logic ROUND_HALF_UP = 1'b1;

endpackage : fixed_point_pkg

// File: rtl/fixed_point_round_sat.sv
// -----------------------------------------------------------------------------
// fixed_point_round_sat
// Combinational rescale of a 2N-bit Q(2I.2F) product back to N-bit Q(I.F):
// optional round-half-up, then saturate (or wrap) into N bits.
// Ports:
//   prod     in  2N  exact signed product
//   mode     in  1   ROUND_TRUNC / ROUND_HALF_UP
//   result   out N   rescaled, clamped or wrapped value
//   overflow out 1   rounded value did not fit in N bits
// -----------------------------------------------------------------------------
module fixed_point_round_sat
    import fixed_point_pkg::*;
#(
    parameter int N        = 5,
    parameter int F        = 2,
    parameter int SATURATE = 1
) (
    input  logic [2*N-1:0] prod,
    input  logic           mode,
    output logic [N-1:0]   result,
    output logic           overflow
);

    localparam int W = 2 * N + 1;

    // 2^(F-1) for F > 0 and zero for F = 0, without ever forming a negative shift.
    localparam logic [W-1:0] HALF = (W'(1) << F) >> 1;

    logic [W-1:0] prod_ext_s;
    logic [W-1:0] bias_s;
    logic [W-1:0] sum_s;
    logic [W-1:0] r_s;
    logic [N+1:0] hi_s;
    logic [N-1:0] sat_s;

    // One guard bit above the product keeps the rounding add from overflowing.
    assign prod_ext_s = {prod[2*N-1], prod};
    assign bias_s     = (mode == ROUND_HALF_UP) ? HALF : {W{1'b0}};
    assign sum_s      = prod_ext_s + bias_s;
    assign r_s        = W'($signed(sum_s) >>> F);

    // The value fits in N bits exactly when bits [W-1:N-1] are all copies of the sign.
    assign hi_s     = r_s[W-1:N-1];
    assign overflow = ~((&hi_s) | ~(|hi_s));

    assign sat_s  = r_s[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    assign result = (overflow && (SATURATE != 0)) ? sat_s : r_s[N-1:0];

endmodule : fixed_point_round_sat

// File: rtl/fixed_point_mul_sat.sv
// -----------------------------------------------------------------------------
// fixed_point_mul_sat
// Sequential signed Q(I.F) multiplier: one radix-2 partial product per clock,
// then a rounding/saturation stage. Latency N+1 clocks from the start edge.
// Ports:
//   clk        in  1  rising-edge clock
//   rst        in  1  asynchronous active-high reset
//   start      in  1  request, sampled only while idle
//   a, b       in  N  signed operands
//   round_mode in  1  0 = truncate, 1 = round half up
//   busy       out 1  multiply in flight
//   done       out 1  one-cycle pulse when result/overflow update
//   result     out N  signed product
//   overflow   out 1  rounded product did not fit in N bits
// -----------------------------------------------------------------------------
module fixed_point_mul_sat
    import fixed_point_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = 3,
    parameter int FRACTIONAL_PART_WIDTH = 2,
    parameter int SATURATE              = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] a,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] b,
    input  logic                                              round_mode,
    output logic                                              busy,
    output logic                                              done,
    output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] result,
    output logic                                              overflow
);

    localparam int N     = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             mode_q, mode_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N-1:0]     result_q, result_d;
    logic             ovf_q, ovf_d;

    logic [2*N-1:0]   pp_s;
    logic [N-1:0]     rs_result_s;
    logic             rs_ovf_s;

    // Partial product for the current bit: sign-extended multiplicand weighted by 2^i.
    assign pp_s = {{N{a_q[N-1]}}, a_q} << cnt_q;

    fixed_point_round_sat #(
        .N        (N),
        .F        (FRACTIONAL_PART_WIDTH),
        .SATURATE (SATURATE)
    ) u_round_sat (
        .prod     (acc_q),
        .mode     (mode_q),
        .result   (rs_result_s),
        .overflow (rs_ovf_s)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = round_mode;
                    acc_d   = {(2*N){1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_MUL;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_MUL: begin
                // The top multiplier bit carries negative weight in two's complement.
                if (b_q[cnt_q]) begin
                    if (cnt_q == CNT_LAST) begin
                        acc_d = acc_q - pp_s;
                    end else begin
                        acc_d = acc_q + pp_s;
                    end
                end else begin
                    acc_d = acc_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_FINISH: begin
                result_d = rs_result_s;
                ovf_d    = rs_ovf_s;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            a_q      <= {N{1'b0}};
            b_q      <= {N{1'b0}};
            mode_q   <= 1'b0;
            acc_q    <= {(2*N){1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {N{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;

endmodule : fixed_point_mul_sat

// File: doc/fixed_point_mul_sat.md
# fixed_point_mul_sat

Sequential signed fixed-point multiplier with a selectable rounding mode, saturation and an overflow flag. It is the parametrised successor of `fixed_point_mul` and keeps its start/done handshake, so existing callers in the function evaluator port over with an added reset and mode input. The datapath is one radix-2 partial product per clock, which keeps area small for the plotter's wide-format variants.

## Interface
- `INTEGER_PART_WIDTH`, default 3: integer bits, including the sign bit.
- `FRACTIONAL_PART_WIDTH`, default 2: fractional bits, F; F = 0 is legal.
- `SATURATE`, default 1: 1 clamps out-of-range results; 0 wraps them (keeps the low N bits).
- N = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH (local).

Ports:
- `clk`  in  1  sole clock; rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  N  signed multiplicand, two's complement, Q(I.F).
- `b`  in  N  signed multiplier, Q(I.F).
- `round_mode`  in  1  0 = truncate (floor); 1 = round half up.
- `busy`  out  1  high while a multiply is in flight.
- `done`  out  1  one-cycle pulse when `result` and `overflow` update.
- `result`  out  N  signed Q(I.F) product.
- `overflow`  out  1  the exact rounded product did not fit in N bits.

## Operation
- States: IDLE, MUL, FINISH.
- IDLE, with `start`=1:
  - latch `a`, `b` and `round_mode`;
  - clear the 2N-bit accumulator and load the iteration counter with 0;
  - go to MUL.
- MUL, iteration i = 0..N-1:
  - if b[i]=1, add sign_ext(a) << i to the accumulator;
  - for i = N-1 the partial product is subtracted (two's-complement sign weight);
  - after N iterations go to FINISH.
- FINISH:
  - P = exact 2N-bit product.
  - Rounding, mode 0: R = P >>> F (arithmetic shift).
  - Rounding, mode 1: R = (P + 2^(F-1)) >>> F. When F = 0, R = P.
  - R is evaluated at 2N+1 bits so the rounding add cannot overflow.
  - If R > 2^(N-1)-1 or R < -2^(N-1): `overflow`=1. With SATURATE=1, `result` is clamped to max or min. With SATURATE=0, `result` = R[N-1:0].
  - Otherwise `overflow`=0 and `result` = R[N-1:0].
  - Pulse `done` and return to IDLE.
- `start` while not in IDLE is ignored; no queueing.
- Operand or mode changes after the start edge have no effect.
- `result` and `overflow` hold their values until the next FINISH.
- `rst` asserted at any time, including mid-MUL:
  - immediately go to IDLE;
  - `busy`=0, `done`=0, `result`=0, `overflow`=0, accumulator cleared;
  - the operation is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `overflow`=0; state IDLE.
- Start accepted at rising edge k. `busy` is high from after edge k until after edge k+N+1.
- MUL occupies edges k+1..k+N. FINISH registers outputs at edge k+N+1.
- `done` is high for exactly the cycle following edge k+N+1. Latency is N+1 clocks.
- Back-to-back operation: `start` held high during the `done` cycle is accepted on the next edge. Throughput is one operation per N+2 clocks.
- `start` in the same cycle as `done` is sampled while the state is already IDLE, so it is accepted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `fixed_point_pkg`:
  - state encoding constants (IDLE, MUL, FINISH);
  - rounding-mode constants `ROUND_TRUNC`=0, `ROUND_HALF_UP`=1.
- Sub-module `fixed_point_round_sat`:
  - combinational;
  - takes the 2N-bit product, mode, and the F/N/SATURATE parameters;
  - produces the N-bit result and overflow;
  - reused later by the divider.
- Top-level contents: FSM, iteration counter (clog2(N) bits), operand registers, accumulator, output registers.

## Test plan
All scenarios use I=3, F=2 (raw range -16..15) unless stated otherwise.
- Basic product: a=6 (1.5), b=8 (2.0), mode 0 → `result`=12, `overflow`=0; `done` exactly 6 clocks after the start edge, one cycle wide.
- Rounding: a=1, b=2, mode 0 → 0; mode 1 → 1. a=-1, b=2, mode 0 → -1; mode 1 → 0.
- Saturation:
  - a=8, b=8 → 15, `overflow`=1;
  - a=-16, b=-16 → 15, `overflow`=1;
  - a=-16, b=1 → -4, `overflow`=0;
  - with SATURATE=0, a=8, b=8 → raw 16 wraps to -16, `overflow`=1.
- Handshake:
  - pulse `start` mid-MUL with new operands → ignored, the first result is unchanged;
  - `start` held through `done` → next operation begins on the following edge.
- Reset: assert `rst` three clocks into MUL → all outputs 0 immediately and no `done`; a following start with a=6, b=8 → 12.
- Exhaustive: sweep all 1024 operand pairs × both modes, with a scoreboard computing the rounded and saturated reference value; repeat with F=0 and with I=8, F=8 on random operands.
